// File: rtl/lift_plant_if.sv
// Command/indication bundle between the lift controller (master) and the
// cabin-and-door plant (slave). Plain level signalling, no handshake.
interface lift_plant_if #(
  parameter int FLOORS = 4,
  parameter int FW     = (FLOORS > 1) ? $clog2(FLOORS) : 1
);
  logic              motor_up;
  logic              motor_dn;
  logic              door_open_cmd;
  logic              door_close_cmd;
  logic [FLOORS-1:0] call_req;
  logic [FW-1:0]     floor_pos;
  logic              at_floor;
  logic              moving;
  logic              door_opened;
  logic              door_closed;
  logic [FLOORS-1:0] call_pending;
  logic              fault;

  modport master (
    output motor_up, motor_dn, door_open_cmd, door_close_cmd, call_req,
    input  floor_pos, at_floor, moving, door_opened, door_closed,
           call_pending, fault
  );

  modport slave (
    input  motor_up, motor_dn, door_open_cmd, door_close_cmd, call_req,
    output floor_pos, at_floor, moving, door_opened, door_closed,
           call_pending, fault
  );
endinterface

// File: rtl/lift_plant_model.sv
// Cabin-and-door plant: turns motor/door commands into floor position,
// door state and latched call indications; illegal commands latch a fault.
module lift_plant_model #(
  parameter int FLOORS        = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  lift_plant_if.slave plant,
  output logic [2:0]  state_dbg
);
  localparam int FW = $clog2(FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MOVE_UP      = 3'd1,
    MOVE_DN      = 3'd2,
    DOOR_OPENING = 3'd3,
    DOOR_OPEN    = 3'd4,
    DOOR_CLOSING = 3'd5,
    FAULT        = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     travel_q, travel_d;
  logic [DW-1:0]     door_q, door_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              at_floor_q, at_floor_d;
  logic              moving_q, moving_d;
  logic              opened_q, opened_d;
  logic              closed_q, closed_d;
  logic [FLOORS-1:0] pend_q, pend_d;
  logic              fault_q, fault_d;
  logic [FLOORS-1:0] clr;
  logic              bad_cmd;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      travel_q   <= '0;
      door_q     <= '0;
      floor_q    <= '0;
      at_floor_q <= 1'b1;
      moving_q   <= 1'b0;
      opened_q   <= 1'b0;
      closed_q   <= 1'b1;
      pend_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      travel_q   <= travel_d;
      door_q     <= door_d;
      floor_q    <= floor_d;
      at_floor_q <= at_floor_d;
      moving_q   <= moving_d;
      opened_q   <= opened_d;
      closed_q   <= closed_d;
      pend_q     <= pend_d;
      fault_q    <= fault_d;
    end
  end

  // Any of these sends the plant to FAULT from every non-FAULT state.
  assign bad_cmd =
      (plant.motor_up && plant.motor_dn) ||
      ((plant.motor_up || plant.motor_dn) && !closed_q) ||
      (state_q == IDLE && plant.motor_up && floor_q == FW'(FLOORS-1)) ||
      (state_q == IDLE && plant.motor_dn && floor_q == '0) ||
      ((state_q == MOVE_UP || state_q == MOVE_DN) && plant.door_open_cmd) ||
      (state_q == MOVE_UP && plant.motor_dn) ||
      (state_q == MOVE_DN && plant.motor_up);

  always_comb begin
    state_d    = state_q;
    travel_d   = travel_q;
    door_d     = door_q;
    floor_d    = floor_q;
    at_floor_d = at_floor_q;
    moving_d   = moving_q;
    opened_d   = opened_q;
    closed_d   = closed_q;
    fault_d    = fault_q;
    clr        = '0;

    if (state_q != FAULT && bad_cmd) begin
      state_d  = FAULT;
      fault_d  = 1'b1;
      moving_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (plant.motor_up || plant.motor_dn) begin
            state_d    = plant.motor_up ? MOVE_UP : MOVE_DN;
            travel_d   = '0;
            at_floor_d = 1'b0;
            moving_d   = 1'b1;
          end else if (plant.door_open_cmd) begin
            state_d  = DOOR_OPENING;
            door_d   = '0;
            closed_d = 1'b0;
          end
        end
        MOVE_UP, MOVE_DN: begin
          // A dropped motor command stalls the cabin without losing progress.
          if ((state_q == MOVE_UP && plant.motor_up) ||
              (state_q == MOVE_DN && plant.motor_dn)) begin
            if (travel_q == TW'(TRAVEL_CYCLES-1)) begin
              floor_d    = (state_q == MOVE_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
              at_floor_d = 1'b1;
              moving_d   = 1'b0;
              state_d    = IDLE;
            end else begin
              travel_d = travel_q + TW'(1);
              moving_d = 1'b1;
            end
          end else begin
            moving_d = 1'b0;
          end
        end
        DOOR_OPENING: begin
          if (plant.door_close_cmd) begin
            state_d = DOOR_CLOSING;
            door_d  = '0;
          end else if (door_q == DW'(DOOR_CYCLES-1)) begin
            state_d  = DOOR_OPEN;
            opened_d = 1'b1;
          end else begin
            door_d = door_q + DW'(1);
          end
        end
        DOOR_OPEN: begin
          if (plant.door_close_cmd) begin
            state_d  = DOOR_CLOSING;
            door_d   = '0;
            opened_d = 1'b0;
          end
        end
        DOOR_CLOSING: begin
          if (plant.door_open_cmd) begin
            state_d = DOOR_OPENING;
            door_d  = '0;
          end else if (door_q == DW'(DOOR_CYCLES-1)) begin
            state_d  = IDLE;
            closed_d = 1'b1;
          end else begin
            door_d = door_q + DW'(1);
          end
        end
        FAULT: begin
          fault_d  = 1'b1;
          moving_d = 1'b0;
        end
        default: begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          moving_d = 1'b0;
        end
      endcase
    end

    // A call is served on the edge the door reaches fully open; a new press wins.
    if (state_d == DOOR_OPEN && state_q != DOOR_OPEN)
      clr = FLOORS'(1) << floor_q;
    pend_d = (pend_q & ~clr) | plant.call_req;
  end

  assign plant.floor_pos    = floor_q;
  assign plant.at_floor     = at_floor_q;
  assign plant.moving       = moving_q;
  assign plant.door_opened  = opened_q;
  assign plant.door_closed  = closed_q;
  assign plant.call_pending = pend_q;
  assign plant.fault        = fault_q;
  assign state_dbg          = state_q;
endmodule

// File: tb/tb_lift_plant_model.sv
// Bench for lift_plant_model: directed scenarios then randomized commands,
// every cycle compared against a behavioural cabin/door model.
module tb_lift_plant_model;
  localparam int F = 4;
  localparam int T = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state_dbg;
  int         checks = 0;
  int         failures = 0;

  lift_plant_if #(.FLOORS(F)) bus ();

  lift_plant_model #(.FLOORS(F), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .plant    (bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural model: direction of travel, edges left to arrive, door activity.
  int         m_pos, m_dir, m_left, m_door, m_dleft; // m_door: 0 shut,1 opening,2 open,3 closing
  bit         m_at, m_mov, m_opened, m_closed, m_fault;
  logic [F-1:0] m_pend;

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_left = 0; m_door = 0; m_dleft = 0;
    m_at = 1; m_mov = 0; m_opened = 0; m_closed = 1; m_fault = 0; m_pend = '0;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit op, input bit cl,
                            input logic [F-1:0] req);
    logic [F-1:0] served;
    bit idle, bad;
    served = '0;
    idle = (m_dir == 0) && (m_door == 0);
    if (!m_fault) begin
      bad = (up && dn) || ((up || dn) && !m_closed) ||
            (idle && up && m_pos == F-1) || (idle && dn && m_pos == 0) ||
            (m_dir != 0 && op) || (m_dir > 0 && dn) || (m_dir < 0 && up);
      if (bad) begin
        m_fault = 1; m_mov = 0;
      end else if (m_dir != 0) begin
        if ((m_dir > 0 && up) || (m_dir < 0 && dn)) begin
          m_left--;
          if (m_left == 0) begin
            m_pos += m_dir; m_dir = 0; m_at = 1; m_mov = 0;
          end else m_mov = 1;
        end else m_mov = 0;
      end else begin
        case (m_door)
          0: if (up)      begin m_dir = 1;  m_left = T; m_at = 0; m_mov = 1; end
             else if (dn) begin m_dir = -1; m_left = T; m_at = 0; m_mov = 1; end
             else if (op) begin m_door = 1; m_dleft = D; m_closed = 0; end
          1: if (cl) begin m_door = 3; m_dleft = D; end
             else begin
               m_dleft--;
               if (m_dleft == 0) begin m_door = 2; m_opened = 1; served[m_pos] = 1'b1; end
             end
          2: if (cl) begin m_door = 3; m_dleft = D; m_opened = 0; end
          default: if (op) begin m_door = 1; m_dleft = D; end
             else begin
               m_dleft--;
               if (m_dleft == 0) begin m_door = 0; m_closed = 1; end
             end
        endcase
      end
    end
    m_pend = (m_pend & ~served) | req;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("floor_pos",    32'(bus.floor_pos),    32'(m_pos));
    chk("at_floor",     32'(bus.at_floor),     32'(m_at));
    chk("moving",       32'(bus.moving),       32'(m_mov));
    chk("door_opened",  32'(bus.door_opened),  32'(m_opened));
    chk("door_closed",  32'(bus.door_closed),  32'(m_closed));
    chk("call_pending", 32'(bus.call_pending), 32'(m_pend));
    chk("fault",        32'(bus.fault),        32'(m_fault));
  endtask

  task automatic set_in(input bit up, input bit dn, input bit op, input bit cl,
                        input logic [F-1:0] req);
    bus.motor_up = up; bus.motor_dn = dn;
    bus.door_open_cmd = op; bus.door_close_cmd = cl; bus.call_req = req;
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic tick();
    bit up, dn, op, cl, r;
    logic [F-1:0] req;
    up = bus.motor_up; dn = bus.motor_dn; op = bus.door_open_cmd;
    cl = bus.door_close_cmd; req = bus.call_req; r = rst;
    @(posedge clk);
    #1;
    if (!r) model_reset();
    else model_step(up, dn, op, cl, req);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, '0);
    tick();
    rst = 1'b1;
  endtask

  bit up_h, dn_h;
  int stuck;

  initial begin
    model_reset();

    // Reset with every command asserted.
    rst = 1'b0;
    set_in(1, 1, 1, 1, '1);
    tick(); tick();
    chk("rst_floor_pos",   32'(bus.floor_pos), 0);
    chk("rst_door_closed", 32'(bus.door_closed), 1);
    chk("rst_at_floor",    32'(bus.at_floor), 1);
    chk("rst_pending",     32'(bus.call_pending), 0);
    chk("rst_fault",       32'(bus.fault), 0);

    // Continuous upward travel from floor 0.
    rst = 1'b1;
    set_in(1, 0, 0, 0, '0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1)  chk("up_moving_e1", 32'(bus.moving), 1);
      if (e == 8)  chk("up_floor_e8", 32'(bus.floor_pos), 0);
      if (e == 9)  begin chk("up_floor_e9", 32'(bus.floor_pos), 1); chk("up_at_e9", 32'(bus.at_floor), 1); end
      if (e == 17) chk("up_floor_e17", 32'(bus.floor_pos), 1);
      if (e == 18) chk("up_floor_e18", 32'(bus.floor_pos), 2);
      chk("up_no_fault", 32'(bus.fault), 0);
    end

    // Stall for 5 edges after three counted edges.
    do_reset();
    set_in(1, 0, 0, 0, '0);
    for (int e = 1; e <= 14; e++) begin
      if (e == 5)  bus.motor_up = 1'b0;
      if (e == 10) bus.motor_up = 1'b1;
      tick();
      if (e == 7)  chk("stall_moving", 32'(bus.moving), 0);
      if (e == 13) chk("stall_floor_e13", 32'(bus.floor_pos), 0);
      if (e == 14) begin chk("stall_floor_e14", 32'(bus.floor_pos), 1); chk("stall_at_e14", 32'(bus.at_floor), 1); end
    end

    // Door cycle serving a call at floor 0.
    do_reset();
    set_in(0, 0, 0, 0, 4'b0001);
    tick();
    chk("door_pend_set", 32'(bus.call_pending), 32'h1);
    set_in(0, 0, 1, 0, '0);
    tick();
    chk("door_closed_drop", 32'(bus.door_closed), 0);
    set_in(0, 0, 0, 0, '0);
    for (int e = 3; e <= 6; e++) begin
      tick();
      if (e == 5) begin chk("door_not_open_e5", 32'(bus.door_opened), 0); chk("door_pend_e5", 32'(bus.call_pending), 32'h1); end
      if (e == 6) begin chk("door_open_e6", 32'(bus.door_opened), 1); chk("door_pend_clr", 32'(bus.call_pending), 0); end
    end

    // Close, then reopen at the third closing edge.
    set_in(0, 0, 0, 1, '0);
    tick();
    chk("close_opened", 32'(bus.door_opened), 0);
    set_in(0, 0, 0, 0, '0);
    tick(); tick();
    set_in(0, 0, 1, 0, '0);
    tick();
    set_in(0, 0, 0, 0, '0);
    for (int e = 11; e <= 14; e++) begin
      tick();
      chk("reopen_closed", 32'(bus.door_closed), 0);
      if (e == 13) chk("reopen_not_yet", 32'(bus.door_opened), 0);
      if (e == 14) chk("reopen_opened", 32'(bus.door_opened), 1);
    end

    // Motor with door open faults; fault ignores commands until reset.
    set_in(1, 0, 0, 0, '0);
    tick();
    chk("fault_door_open", 32'(bus.fault), 1);
    for (int e = 0; e < 5; e++) begin
      set_in(0, 0, 0, 1, '0);
      tick();
      chk("fault_hold", 32'(bus.fault), 1);
      chk("fault_freeze_open", 32'(bus.door_opened), 1);
    end
    do_reset();
    chk("fault_cleared", 32'(bus.fault), 0);
    chk("fault_rst_closed", 32'(bus.door_closed), 1);

    // Overtravel below floor 0.
    set_in(0, 1, 0, 0, '0);
    tick();
    chk("overtravel_dn", 32'(bus.fault), 1);
    chk("overtravel_floor", 32'(bus.floor_pos), 0);

    // Randomized command sequences with sticky motor intent.
    do_reset();
    up_h = 0; dn_h = 0; stuck = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        up_h = ($urandom_range(0, 2) == 0);
        dn_h = !up_h && ($urandom_range(0, 2) == 0);
      end
      set_in(up_h, dn_h && ($urandom_range(0, 30) != 0),
             $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
             ($urandom_range(0, 7) == 0) ? F'($urandom_range(0, (1 << F) - 1)) : '0);
      if ($urandom_range(0, 40) == 0) bus.motor_dn = 1'b1;
      stuck = m_fault ? stuck + 1 : 0;
      rst = !((stuck > 8) || ($urandom_range(0, 299) == 0));
      if (!rst) stuck = 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
